router_fifo: RTL and testbench
==============================

# router_fifo

Per-port output buffer of the 1x3 router: one instance per destination port, sitting directly downstream of `router_sync`, which drives its `write_enb` bit and `soft_reset`, and consumes its `full`/`empty`. The block stores packet bytes written by the register stage and tags each header byte. When that header is read out, it tracks the packet length so the output is driven only while a packet is being drained.

## Interface
- `WIDTH`, 8: data byte width.
- `DEPTH`, 16: number of entries; must be a power of two.
- `AW`, 4: pointer index width, equal to log2(`DEPTH`).

- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `soft_reset` input 1: synchronous, active-high flush from `router_sync`, asserted on read timeout.
- `write_enb` input 1: write request for `data_in`.
- `read_enb` input 1: read request from the destination.
- `lfd_state` input 1: marks the current `data_in` as a header byte.
- `data_in` input `WIDTH`: byte to store.
- `data_out` output `WIDTH`: registered read data.
- `full` output 1: combinational; high when the FIFO holds `DEPTH` entries.
- `empty` output 1: combinational; high when the FIFO holds 0 entries.

## Operation
- Storage is `DEPTH` x (`WIDTH`+1). Bit `WIDTH` of each entry is the header tag, written from `lfd_state`.
- Write and read pointers are (`AW`+1) bits wide and wrap modulo 2·`DEPTH`.
  - `empty`: pointers are equal.
  - `full`: the MSBs differ and the low `AW` bits are equal.
- A write occurs when `write_enb` is high and `full` is low. A write while `full` is dropped, even if a read happens in the same cycle.
- A read occurs when `read_enb` is high and `empty` is low. A read while `empty` is ignored; `data_out` and the counter are unchanged.
- A simultaneous write and read with the FIFO neither full nor empty both proceed; occupancy is unchanged.
- Packet counter is 7 bits.
  - Reading a header-tagged entry loads it with `data[7:2]` + 1 (payload length plus parity).
  - Reading a non-header entry decrements the counter if it is non-zero.
- `data_out` behaviour:
  - On a read, it loads the read entry's `WIDTH` data bits.
  - With no read and counter == 0, it goes to the idle value (see Configuration).
  - With no read and counter != 0, it holds its value.
- `soft_reset` clears both pointers and the counter, and sets `data_out` idle. Memory contents are don't-care afterwards. `soft_reset` has priority over a same-cycle read or write.
- `reset` low has the same effect asynchronously and overrides everything else.

## Timing
- Reset values: `data_out` is idle, `full` = 0, `empty` = 1, pointers = 0, counter = 0.
- Write-to-`empty` deassert: `empty` falls in the cycle after the write edge.
- Read latency: 1 cycle. `data_out` is valid after the edge that samples `read_enb` = 1.
- `full`/`empty` reflect the pointers after each edge; there is no look-ahead.
- Pointers wrap from index 15 to 0 with no bubble.
- Reset released mid-packet: the partial packet is lost; the FIFO is empty and idle.
- After the parity byte is read, the counter is 0. The next cycle without a read returns `data_out` to idle.

## Configuration
- `ROUTER_FIFO_TRISTATE_EN`:
  - Defined: the idle value of `data_out` is all-Z, so the three port FIFOs can share a bus.
  - Undefined: the idle value is `8'h00`, and the block contains no tristate logic.
  - Either way, all other behaviour is identical.

## Test plan
- Reset: `reset` = 0 mid-run → `empty` = 1, `full` = 0, `data_out` idle, within the same cycle.
- Single packet: write header `8'h0C` (length 3) with `lfd_state` = 1, then `8'hA1`, `8'hA2`, `8'hA3`, parity `8'h5E`; read 5 bytes back to back → `data_out` = `0C`, `A1`, `A2`, `A3`, `5E`, then idle on the next cycle.
- Full: 16 writes → `full` = 1. A 17th write is dropped. One read → `full` = 0, `data_out` = first byte.
- Empty read: `read_enb` = 1 while `empty` → `data_out` stays idle; the read pointer does not move.
- Wrap plus concurrency: fill 10, then hold `write_enb` = `read_enb` = 1 for 20 cycles → occupancy stays 10, data order is preserved across the wrap, and `full`/`empty` stay low.
- Soft reset: with 6 entries and the counter non-zero, pulse `soft_reset` together with `write_enb` → next cycle `empty` = 1, `data_out` idle, and the write is discarded.

Source files
------------

// File: rtl/router_fifo_if.sv
// Bus between router_sync/register stage and one per-port router_fifo.
// The master side drives write/read requests and data; the slave side is
// the FIFO returning read data and occupancy flags.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/router_fifo.sv
// router_fifo: per-destination output buffer of the 1x3 router.
// Stores packet bytes with a header tag bit and tracks the remaining packet
// length as bytes are drained, so data_out is only driven mid-packet.
// Optional build macro ROUTER_FIFO_TRISTATE_EN: when defined, the idle value
// of data_out is high-Z so the three port FIFOs can share one bus; when
// undefined the idle value is zero and no tristate logic is present.
// DEPTH must equal 2**AW.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic          clock,
  input logic          reset,
  router_fifo_if.slave bus
);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [6:0]       pkt_count;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH:0]   rd_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             do_write;
  logic             do_read;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.full   = fifo_full;
  assign bus.empty  = fifo_empty;

  // Requests are qualified by occupancy; a write into a full FIFO is lost
  // even if a read frees a slot on the same edge.
  assign do_write = bus.write_enb && !fifo_full;
  assign do_read  = bus.read_enb && !fifo_empty;
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Storage array: header tag in the top bit, no reset needed on contents.
  always_ff @(posedge clock) begin
    if (do_write && !bus.soft_reset)
      mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  // Write and read pointers, flushed by hard or soft reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_read)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Registered read data and remaining-length counter; a header loads its
  // payload length plus one for the trailing parity byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      pkt_count <= '0;
    end else if (bus.soft_reset) begin
      data_q    <= '0;
      pkt_count <= '0;
    end else if (do_read) begin
      data_q <= rd_entry[WIDTH-1:0];
      if (rd_entry[WIDTH])
        pkt_count <= 7'(rd_entry[WIDTH-1:2]) + 7'd1;
      else if (pkt_count != 7'd0)
        pkt_count <= pkt_count - 7'd1;
    end else if (pkt_count == 7'd0) begin
      data_q <= '0;
    end
  end

`ifdef ROUTER_FIFO_TRISTATE_EN
  logic drive_q;

  // Output enable follows the same load/idle decisions as data_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      drive_q <= 1'b0;
    else if (bus.soft_reset)
      drive_q <= 1'b0;
    else if (do_read)
      drive_q <= 1'b1;
    else if (pkt_count == 7'd0)
      drive_q <= 1'b0;
  end

  assign bus.data_out = drive_q ? data_q : {WIDTH{1'bz}};
`else
  assign bus.data_out = data_q;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: reset, packet drain, full/empty limits,
// wrap with concurrent traffic, soft reset and asynchronous reset.
module tb_router_fifo;

  logic clock;
  logic reset;
  int   tests;
  int   failures;
  logic [7:0] idle_val;
  logic [7:0] model_q [$];
  logic [7:0] exp_byte;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Drive every master-side input at once.
  task automatic applyStimulus(input logic we, input logic re, input logic lfd,
                               input logic [7:0] din, input logic srst);
    bus.write_enb  = we;
    bus.read_enb   = re;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    bus.soft_reset = srst;
  endtask

  // Advance one clock edge and settle just past it.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // One comparison with failure accounting.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
`ifdef ROUTER_FIFO_TRISTATE_EN
    idle_val = 8'hzz;
`else
    idle_val = 8'h00;
`endif

    // Power-on reset state
    reset = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 0);
    #2;
    checkOutput("rst_empty", {7'd0, bus.empty}, 8'd1);
    checkOutput("rst_full", {7'd0, bus.full}, 8'd0);
    checkOutput("rst_data", bus.data_out, idle_val);
    #10 reset = 1'b1;
    cycle();

    // Single packet: header 0C (length 3), three payload bytes, parity
    applyStimulus(1, 0, 1, 8'h0C, 0);
    cycle();
    checkOutput("pkt_empty_fall", {7'd0, bus.empty}, 8'd0);
    applyStimulus(1, 0, 0, 8'hA1, 0); cycle();
    applyStimulus(1, 0, 0, 8'hA2, 0); cycle();
    applyStimulus(1, 0, 0, 8'hA3, 0); cycle();
    applyStimulus(1, 0, 0, 8'h5E, 0); cycle();
    applyStimulus(0, 1, 0, 8'h00, 0);
    cycle(); checkOutput("pkt_hdr", bus.data_out, 8'h0C);
    cycle(); checkOutput("pkt_a1", bus.data_out, 8'hA1);
    applyStimulus(0, 0, 0, 8'h00, 0);
    cycle(); checkOutput("pkt_hold", bus.data_out, 8'hA1);
    applyStimulus(0, 1, 0, 8'h00, 0);
    cycle(); checkOutput("pkt_a2", bus.data_out, 8'hA2);
    cycle(); checkOutput("pkt_a3", bus.data_out, 8'hA3);
    cycle(); checkOutput("pkt_parity", bus.data_out, 8'h5E);
    checkOutput("pkt_empty", {7'd0, bus.empty}, 8'd1);
    applyStimulus(0, 0, 0, 8'h00, 0);
    cycle(); checkOutput("pkt_idle", bus.data_out, idle_val);

    // Fill to 16, drop a 17th write, then drain in order
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 0, 8'(8'h10 + i), 0);
      cycle();
      if (i == 14) checkOutput("full_at15", {7'd0, bus.full}, 8'd0);
    end
    checkOutput("full_at16", {7'd0, bus.full}, 8'd1);
    applyStimulus(1, 0, 0, 8'hFF, 0);
    cycle();
    checkOutput("full_drop", {7'd0, bus.full}, 8'd1);
    applyStimulus(0, 1, 0, 8'h00, 0);
    cycle();
    checkOutput("full_first", bus.data_out, 8'h10);
    checkOutput("full_clear", {7'd0, bus.full}, 8'd0);
    for (int i = 1; i < 16; i++) begin
      cycle();
      checkOutput("full_drain", bus.data_out, 8'(8'h10 + i));
    end
    checkOutput("full_drained", {7'd0, bus.empty}, 8'd1);

    // Read while empty leaves output idle and pointers untouched
    applyStimulus(0, 0, 0, 8'h00, 0);
    cycle();
    applyStimulus(0, 1, 0, 8'h00, 0);
    cycle();
    checkOutput("er_data", bus.data_out, idle_val);
    checkOutput("er_empty", {7'd0, bus.empty}, 8'd1);
    applyStimulus(1, 0, 0, 8'h77, 0); cycle();
    applyStimulus(0, 1, 0, 8'h00, 0); cycle();
    checkOutput("er_next", bus.data_out, 8'h77);
    checkOutput("er_empty2", {7'd0, bus.empty}, 8'd1);

    // Fill 10, then 20 cycles of simultaneous write and read across the wrap
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 8'(8'h20 + i), 0);
      model_q.push_back(8'(8'h20 + i));
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 0, 8'(8'h40 + i), 0);
      model_q.push_back(8'(8'h40 + i));
      exp_byte = model_q.pop_front();
      cycle();
      checkOutput("wrap_data", bus.data_out, exp_byte);
      checkOutput("wrap_full", {7'd0, bus.full}, 8'd0);
      checkOutput("wrap_empty", {7'd0, bus.empty}, 8'd0);
    end
    applyStimulus(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) begin
      exp_byte = model_q.pop_front();
      if (i == 9) checkOutput("wrap_last_not_empty", {7'd0, bus.empty}, 8'd0);
      cycle();
      checkOutput("wrap_drain", bus.data_out, exp_byte);
    end
    checkOutput("wrap_empty_end", {7'd0, bus.empty}, 8'd1);

    // Soft reset mid-packet with a concurrent write
    applyStimulus(1, 0, 1, 8'h14, 0); cycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 8'(8'h61 + i), 0);
      cycle();
    end
    applyStimulus(0, 1, 0, 8'h00, 0); cycle();
    checkOutput("sr_hdr", bus.data_out, 8'h14);
    applyStimulus(1, 0, 0, 8'h99, 1); cycle();
    checkOutput("sr_empty", {7'd0, bus.empty}, 8'd1);
    checkOutput("sr_full", {7'd0, bus.full}, 8'd0);
    checkOutput("sr_data", bus.data_out, idle_val);
    applyStimulus(0, 0, 0, 8'h00, 0); cycle();
    checkOutput("sr_discard", {7'd0, bus.empty}, 8'd1);
    applyStimulus(1, 0, 0, 8'h55, 0); cycle();
    applyStimulus(0, 1, 0, 8'h00, 0); cycle();
    checkOutput("sr_after", bus.data_out, 8'h55);
    applyStimulus(0, 0, 0, 8'h00, 0); cycle();
    checkOutput("sr_count_clr", bus.data_out, idle_val);

    // Asynchronous reset in the middle of a packet
    applyStimulus(1, 0, 1, 8'h0C, 0); cycle();
    applyStimulus(1, 0, 0, 8'hA1, 0); cycle();
    applyStimulus(0, 1, 0, 8'h00, 0); cycle();
    checkOutput("ar_hdr", bus.data_out, 8'h0C);
    applyStimulus(0, 0, 0, 8'h00, 0);
    reset = 1'b0;
    #2;
    checkOutput("ar_empty", {7'd0, bus.empty}, 8'd1);
    checkOutput("ar_full", {7'd0, bus.full}, 8'd0);
    checkOutput("ar_data", bus.data_out, idle_val);
    #1 reset = 1'b1;
    cycle();
    checkOutput("ar_post_empty", {7'd0, bus.empty}, 8'd1);
    checkOutput("ar_post_data", bus.data_out, idle_val);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
